// File: rtl/timer_if.sv
// Register-block-side interface of the timer up-counter stage.
// With TIMER_OVF_IRQ_EN defined it also carries the ovf_st status and the ovf_clr pulse.
interface timer_if #(
  parameter int DATA_W = 32
);
  logic                  cnt_en;
  logic                  timer_en;
  logic                  wr_lo;
  logic                  wr_hi;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [2*DATA_W-1:0]   cmp_val;
  logic                  int_en;
  logic                  int_clr;
  logic [2*DATA_W-1:0]   cnt_val;
  logic                  int_st;
  logic                  tim_int;
`ifdef TIMER_OVF_IRQ_EN
  logic                  ovf_clr;
  logic                  ovf_st;

  modport master (
    output cnt_en, timer_en, wr_lo, wr_hi, wdata, wstrb, cmp_val, int_en, int_clr, ovf_clr,
    input  cnt_val, int_st, tim_int, ovf_st
  );
  modport slave (
    input  cnt_en, timer_en, wr_lo, wr_hi, wdata, wstrb, cmp_val, int_en, int_clr, ovf_clr,
    output cnt_val, int_st, tim_int, ovf_st
  );
`else
  modport master (
    output cnt_en, timer_en, wr_lo, wr_hi, wdata, wstrb, cmp_val, int_en, int_clr,
    input  cnt_val, int_st, tim_int
  );
  modport slave (
    input  cnt_en, timer_en, wr_lo, wr_hi, wdata, wstrb, cmp_val, int_en, int_clr,
    output cnt_val, int_st, tim_int
  );
`endif
endinterface

// File: rtl/timer_counter.sv
// 64-bit timer up-counter with byte-strobed half loads, compare match and sticky interrupt status.
// Optional macro TIMER_OVF_IRQ_EN adds a sticky, unmaskable wrap-overflow status (ovf_st/ovf_clr).
module timer_counter #(
  parameter int DATA_W        = 32,
  parameter int RST_CMP_MATCH = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  timer_if.slave  bus
);
  localparam int CNT_W = 2 * DATA_W;
  localparam int LANES = DATA_W / 8;

  if (RST_CMP_MATCH != 0) begin : g_rst_cmp_match_unsupported
    $error("timer_counter: RST_CMP_MATCH must be 0");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timer_en_q;
  logic             int_st_q, int_st_d;
  logic             fall;
  logic             match;
  logic             any_wr;

  assign fall   = timer_en_q & ~bus.timer_en;
  assign match  = (cnt_q == bus.cmp_val);
  assign any_wr = bus.wr_lo | bus.wr_hi;

  always_comb begin
    // NOTE: assign the default before any branch so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (fall) begin
      cnt_d = '0;
    end else if (any_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wstrb[i]) begin
          if (bus.wr_lo) cnt_d[8*i +: 8]        = bus.wdata[8*i +: 8];
          if (bus.wr_hi) cnt_d[DATA_W+8*i +: 8] = bus.wdata[8*i +: 8];
        end
      end
    end else if (bus.cnt_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Set beats clear so a count parked on cmp_val keeps the status asserted.
  always_comb begin
    int_st_d = int_st_q;
    if (match)            int_st_d = 1'b1;
    else if (bus.int_clr) int_st_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (!rst_n) begin
      cnt_q      <= '0;
      timer_en_q <= 1'b0;
      int_st_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timer_en_q <= bus.timer_en;
      int_st_q   <= int_st_d;
    end
  end

  assign bus.cnt_val = cnt_q;
  assign bus.int_st  = int_st_q;

`ifdef TIMER_OVF_IRQ_EN
  logic ovf_st_q, ovf_st_d;
  logic ovf_set;

  // Wrap is flagged even when a fall clear or write replaces the increment.
  assign ovf_set = bus.cnt_en & (&cnt_q);

  always_comb begin
    ovf_st_d = ovf_st_q;
    if (ovf_set)          ovf_st_d = 1'b1;
    else if (bus.ovf_clr) ovf_st_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_st_q <= 1'b0;
    else        ovf_st_q <= ovf_st_d;
  end

  assign bus.ovf_st  = ovf_st_q;
  assign bus.tim_int = (int_st_q & bus.int_en) | ovf_st_q;
`else
  assign bus.tim_int = int_st_q & bus.int_en;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a behavioural model checked every cycle plus literal checkpoints.
module tb_timer_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  timer_if #(.DATA_W(32)) bus ();

  timer_counter #(.DATA_W(32), .RST_CMP_MATCH(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: the count as a plain 64-bit number, statuses as flags.
  logic [63:0] m_cnt;
  bit          m_st, m_ovf, m_prev_en;
  logic [63:0] m_nxt;
  bit          m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = '0; m_st = 0; m_ovf = 0; m_prev_en = 0;
    end else begin
      m_hit = (m_cnt == bus.cmp_val);
`ifdef TIMER_OVF_IRQ_EN
      if (bus.cnt_en && m_cnt == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf = 1;
      else if (bus.ovf_clr) m_ovf = 0;
`endif
      if (m_prev_en && !bus.timer_en) begin
        m_nxt = 64'd0;
      end else if (bus.wr_lo || bus.wr_hi) begin
        m_nxt = m_cnt;
        for (int b = 0; b < 4; b++) begin
          if (bus.wstrb[b] && bus.wr_lo) m_nxt[8*b +: 8]      = bus.wdata[8*b +: 8];
          if (bus.wstrb[b] && bus.wr_hi) m_nxt[32 + 8*b +: 8] = bus.wdata[8*b +: 8];
        end
      end else if (bus.cnt_en) begin
        m_nxt = m_cnt + 64'd1;
      end else begin
        m_nxt = m_cnt;
      end
      if (m_hit) m_st = 1;
      else if (bus.int_clr) m_st = 0;
      m_prev_en = bus.timer_en;
      m_cnt = m_nxt;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_cnt_val", bus.cnt_val, m_cnt);
    check("model_int_st",  {63'd0, bus.int_st}, {63'd0, m_st});
    check("model_tim_int", {63'd0, bus.tim_int}, {63'd0, (m_st & bus.int_en) | m_ovf});
`ifdef TIMER_OVF_IRQ_EN
    check("model_ovf_st",  {63'd0, bus.ovf_st}, {63'd0, m_ovf});
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cnt_en = 0; bus.wr_lo = 0; bus.wr_hi = 0; bus.int_clr = 0;
    bus.wdata = '0; bus.wstrb = '0;
`ifdef TIMER_OVF_IRQ_EN
    bus.ovf_clr = 0;
`endif
  endtask

  task automatic write(input bit lo, input bit hi, input logic [31:0] d, input logic [3:0] s);
    bus.wr_lo = lo; bus.wr_hi = hi; bus.wdata = d; bus.wstrb = s;
    tick();
    idle();
  endtask

  initial begin
    idle();
    bus.timer_en = 1;
    bus.int_en   = 0;
    bus.cmp_val  = 64'hDEAD_BEEF_0000_0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cnt_val", bus.cnt_val, 64'd0);
    check("reset_int_st",  {63'd0, bus.int_st}, 64'd0);
    check("reset_tim_int", {63'd0, bus.tim_int}, 64'd0);
    rst_n = 1;
    tick();

    // Increment with carry across the halves.
    write(1, 0, 32'hFFFF_FFFE, 4'hF);
    write(0, 1, 32'h0000_0000, 4'hF);
    check("load_fffffffe", bus.cnt_val, 64'h0000_0000_FFFF_FFFE);
    bus.cnt_en = 1;
    tick(); check("inc_1", bus.cnt_val, 64'h0000_0000_FFFF_FFFF);
    tick(); check("inc_carry", bus.cnt_val, 64'h0000_0001_0000_0000);
    tick(); check("inc_3", bus.cnt_val, 64'h0000_0001_0000_0001);
    idle();

    // Byte-strobed write to the high half suppresses a same-cycle increment.
    write(1, 0, 32'h5566_7788, 4'hF);
    write(0, 1, 32'h1122_3344, 4'hF);
    check("load_1122", bus.cnt_val, 64'h1122_3344_5566_7788);
    bus.cnt_en = 1;
    write(0, 1, 32'hAABB_CCDD, 4'b0101);
    check("strobe_hi", bus.cnt_val, 64'h11BB_33DD_5566_7788);
    write(1, 1, 32'h0102_0304, 4'b1111);
    check("both_halves", bus.cnt_val, 64'h0102_0304_0102_0304);

    // Enable fall clears the count over a write and an increment.
    write(1, 0, 32'h0000_0060, 4'hF);
    write(0, 1, 32'h0000_0000, 4'hF);
    bus.cnt_en = 1;
    repeat (4) tick();
    check("count_64", bus.cnt_val, 64'h64);
    bus.timer_en = 0; bus.wr_lo = 1; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    tick();
    idle();
    check("fall_clear", bus.cnt_val, 64'd0);
    bus.timer_en = 1;
    tick();
    check("rise_no_effect", bus.cnt_val, 64'd0);

    // Compare and sticky status, int_en=1.
    bus.cmp_val = 64'd5; bus.int_en = 1; bus.cnt_en = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("cmp_cnt", bus.cnt_val, 64'(k));
      check("cmp_int_st", {63'd0, bus.int_st}, (k >= 6) ? 64'd1 : 64'd0);
      check("cmp_tim_int", {63'd0, bus.tim_int}, (k >= 6) ? 64'd1 : 64'd0);
    end
    bus.int_clr = 1;
    tick();
    bus.int_clr = 0;
    check("clr_int_st", {63'd0, bus.int_st}, 64'd0);
    check("clr_tim_int", {63'd0, bus.tim_int}, 64'd0);
    idle();

    // Same again with the line masked.
    bus.int_en = 0;
    write(1, 1, 32'h0, 4'hF);
    bus.cnt_en = 1;
    repeat (6) tick();
    idle();
    check("mask_cnt", bus.cnt_val, 64'd6);
    check("mask_int_st", {63'd0, bus.int_st}, 64'd1);
    check("mask_tim_int", {63'd0, bus.tim_int}, 64'd0);
    bus.int_en = 1;
    #1;
    check("unmask_tim_int", {63'd0, bus.tim_int}, 64'd1);
    bus.int_clr = 1;
    tick();
    idle();
    check("mask_clr", {63'd0, bus.int_st}, 64'd0);

    // Count held on cmp_val: set wins over clear.
    bus.cmp_val = 64'd9;
    write(1, 0, 32'd9, 4'hF);
    tick();
    check("hold9_int_st", {63'd0, bus.int_st}, 64'd1);
    bus.int_clr = 1;
    tick(); tick();
    idle();
    check("set_over_clr", {63'd0, bus.int_st}, 64'd1);

    // Moving cmp_val onto a held count sets the status.
    bus.cmp_val = 64'h20;
    bus.int_clr = 1;
    tick();
    idle();
    check("cmp_move_clr", {63'd0, bus.int_st}, 64'd0);
    bus.cmp_val = 64'd9;
    tick();
    check("cmp_move_set", {63'd0, bus.int_st}, 64'd1);

    // Wrap from all-ones.
    bus.cmp_val = 64'h1234; bus.int_en = 0;
    bus.int_clr = 1;
    tick();
    idle();
    write(1, 1, 32'hFFFF_FFFF, 4'hF);
    check("load_ones", bus.cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.cnt_en = 1;
    tick();
    idle();
    check("wrap_cnt", bus.cnt_val, 64'd0);
`ifdef TIMER_OVF_IRQ_EN
    check("wrap_ovf_st", {63'd0, bus.ovf_st}, 64'd1);
    check("wrap_tim_int", {63'd0, bus.tim_int}, 64'd1);
    bus.ovf_clr = 1;
    tick();
    idle();
    check("ovf_clr", {63'd0, bus.ovf_st}, 64'd0);
    check("ovf_clr_tim_int", {63'd0, bus.tim_int}, 64'd0);
`else
    check("wrap_tim_int", {63'd0, bus.tim_int}, 64'd0);
`endif

    // Asynchronous reset in the middle of counting.
    bus.cmp_val = 64'd3; bus.int_en = 1; bus.cnt_en = 1;
    repeat (5) tick();
    check("pre_rst_int_st", {63'd0, bus.int_st}, 64'd1);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_cnt", bus.cnt_val, 64'd0);
    check("async_rst_int_st", {63'd0, bus.int_st}, 64'd0);
    check("async_rst_tim_int", {63'd0, bus.tim_int}, 64'd0);
    tick();
    rst_n = 1;
    tick();
    check("post_rst_cnt", bus.cnt_val, 64'd1);
    idle();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Main up-counter stage of the timer IP, directly downstream of the counter-enable/divider control stage.
- Advances a 64-bit count on each cycle its `cnt_en` input is high.
- Supports software load of either 32-bit half through byte-strobed writes from the register block.
- Compares the count against a 64-bit compare value and raises a sticky interrupt status, gated by an interrupt enable.

Parameters:
- DATA_W, 32, width of one register half; counter width is 2*DATA_W.
- RST_CMP_MATCH, 0, reserved; must be 0 (no match evaluation during reset).

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cnt_en  input  1  single-cycle increment enable from counter control
- timer_en  input  1  timer enable bit from register block
- wr_lo  input  1  write strobe for count bits [DATA_W-1:0]
- wr_hi  input  1  write strobe for count bits [2*DATA_W-1:DATA_W]
- wdata  input  DATA_W  write data
- wstrb  input  DATA_W/8  byte-lane enables for wr_lo/wr_hi
- cmp_val  input  2*DATA_W  compare value, held by register block
- int_en  input  1  interrupt enable
- int_clr  input  1  one-cycle pulse; write-1-to-clear of interrupt status
- cnt_val  output  2*DATA_W  current count, registered
- int_st  output  1  sticky compare-match status
- tim_int  output  1  interrupt line = int_st & int_en

Behaviour:
- Reset (rst_n=0, asynchronous): cnt_val=0, int_st=0, tim_int=0, internal timer_en_d=0.
  - Release takes effect on the first clk edge with rst_n=1.
- timer_en_d is timer_en registered each cycle. Falling edge detect: fall = timer_en_d & ~timer_en.
- Count update priority, evaluated per cycle:
  1. fall → cnt_val <= 0. Overrides any write or increment in the same cycle.
  2. wr_lo and/or wr_hi → each selected byte lane (wstrb[i]=1) of the addressed half takes wdata byte i.
     - Unselected lanes and the other half hold their value.
     - wr_lo and wr_hi together → both halves loaded from the same wdata/wstrb.
     - A write in the same cycle as cnt_en suppresses the increment; the written value wins and no +1 is applied.
  3. cnt_en=1 → cnt_val <= cnt_val + 1, full 2*DATA_W width.
     - Carry propagates from the low half to the high half in the same cycle.
     - All-ones wraps to 0.
  4. Otherwise hold.
- cnt_en is honoured regardless of timer_en. Upstream guarantees cnt_en=0 when timer_en=0 or halted.
- Latency: cnt_val reflects an increment or write one cycle after the enabling edge.
- Compare:
  - match = (cnt_val == cmp_val), combinational on registered cnt_val.
  - int_st <= 1 on the edge where match=1, so it rises one cycle after cnt_val first equals cmp_val.
  - int_st is sticky. int_clr=1 clears it, unless match=1 in the same cycle; set wins over clear.
  - While the count is held at cmp_val (slow divider, halt), int_st cannot be cleared.
- cmp_val change that makes match true → int_st sets on the next edge; no edge requirement on the count.
- tim_int is combinational AND of int_st and int_en. int_en=0 masks the line only; status is still recorded.
- Reset asserted mid-count: immediate clear of all state; no partial-write effects survive.

Optional Feature:
- Macro: TIMER_OVF_IRQ_EN.
- Defined:
  - Adds output ovf_st (1) and input ovf_clr (1).
  - ovf_st sets on the edge where cnt_en=1 and cnt_val is all-ones (the wrap), including when the same cycle is a fall clear.
  - ovf_st is sticky; ovf_clr clears it, with set winning on a simultaneous set and clear.
  - tim_int = (int_st & int_en) | ovf_st. Overflow is not maskable by int_en.
  - Reset value 0.
- Not defined: ports absent; wrap to 0 occurs silently; tim_int as above.

Test Plan:
- Increment/carry: load cnt_val=0x0000_0000_FFFF_FFFE via wr_lo+wr_hi, cnt_en high 3 cycles → 0x..FFFF_FFFF, 0x0000_0001_0000_0000, 0x0000_0001_0000_0001.
- Byte-strobe write:
  - cnt_val=0x1122_3344_5566_7788, wr_hi with wdata=0xAABBCCDD, wstrb=4'b0101 → 0x11BB_33DD_5566_7788.
  - Same cycle cnt_en=1 → no increment.
- Enable fall clear: count to 0x64, drop timer_en with cnt_en=1 and wr_lo the same cycle → cnt_val=0 next cycle.
- Compare/sticky:
  - cmp_val=5, int_en=1, cnt_en every cycle from 0 → int_st and tim_int rise the cycle after cnt_val=5.
  - int_clr at cnt_val=7 → both drop.
  - int_en=0 repeat → int_st=1, tim_int=0.
- Set-over-clear: hold cnt_en=0 at cnt_val=cmp_val=9, pulse int_clr → int_st stays 1.
- Wrap/overflow (TIMER_OVF_IRQ_EN defined): load all-ones, one cnt_en → cnt_val=0, ovf_st=1, tim_int=1 with int_en=0. ovf_clr → ovf_st=0.
  - Undefined build: same stimulus → cnt_val=0, tim_int=0.
